// File: rtl/pipe_perf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_perf_pkg
// Description : Shared FSM state and event-channel definitions for the
//               pipeline performance monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_perf_pkg;

    // One-hot-style encoding: bit 0 marks RUN and bit 1 marks DONE, so the
    // status outputs come straight from flop bits.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int EVT_STALL = 0;
    localparam int EVT_FLUSH = 1;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that saturates at all-ones, with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    logic [CNT_W-1:0] r_count;

    assign count = r_count;
    assign sat   = &r_count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && inc && !sat) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_event_counter.sv
`default_nettype none
// ============================================================================
// Module      : pipe_event_counter
// Description : Windowed cycle/event performance counters with a registered
//               indexed read port.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_event_counter
    import pipe_perf_pkg::*;
#(
    parameter int NUM_EVT   = 4,
    parameter int CNT_W     = 32,
    parameter int CYC_LIMIT = 30,
    parameter int IDX_W     = $clog2(NUM_EVT + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               clear_i,
    input  logic [NUM_EVT-1:0] event_i,
    input  logic [IDX_W-1:0]   rd_idx_i,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic [CNT_W-1:0]   cycle_o,
    output logic               running_o,
    output logic               done_o,
    output logic [NUM_EVT-1:0] ovf_o
);

    localparam logic [CNT_W-1:0] c_limit   = CNT_W'(CYC_LIMIT);
    localparam logic [IDX_W-1:0] c_cyc_idx = IDX_W'(NUM_EVT);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_count_en;
    logic                 w_hit_limit;
    logic [CNT_W-1:0]     w_cyc_cnt;
    logic [CNT_W-1:0]     w_cyc_nxt;
    logic                 w_cyc_sat;
    logic [CNT_W-1:0]     w_evt_cnt [NUM_EVT];
    logic [NUM_EVT-1:0]   w_evt_sat;
    logic [NUM_EVT-1:0]   r_ovf;
    logic [CNT_W-1:0]     r_rd_data;
    logic [CNT_W-1:0]     w_rd_sel;

    // Clear pre-empts counting so counters land on zero that edge.
    assign w_count_en  = start_i && !clear_i && (r_state != DONE);
    assign w_cyc_nxt   = w_cyc_sat ? w_cyc_cnt : (w_cyc_cnt + 1'b1);
    assign w_hit_limit = (CYC_LIMIT != 0) && (w_cyc_nxt == c_limit);

    sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (w_count_en),
        .inc   (1'b1),
        .clr   (clear_i),
        .count (w_cyc_cnt),
        .sat   (w_cyc_sat)
    );

    generate
        for (genvar k = 0; k < NUM_EVT; k++) begin : g_evt
            sat_counter #(.CNT_W(CNT_W)) u_evt_cnt (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .en    (w_count_en),
                .inc   (event_i[k]),
                .clr   (clear_i),
                .count (w_evt_cnt[k]),
                .sat   (w_evt_sat[k])
            );
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear_i) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        w_state_nxt = w_hit_limit ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (!start_i) begin
                        w_state_nxt = IDLE;
                    end else if (w_hit_limit) begin
                        w_state_nxt = DONE;
                    end
                end
                DONE:    w_state_nxt = DONE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ovf <= '0;
        end else if (clear_i) begin
            r_ovf <= '0;
        end else if (w_count_en) begin
            r_ovf <= r_ovf | (event_i & w_evt_sat);
        end
    end

    always_comb begin
        w_rd_sel = '0;
        for (int k = 0; k < NUM_EVT; k++) begin
            if (rd_idx_i == IDX_W'(k)) begin
                w_rd_sel = w_evt_cnt[k];
            end
        end
        if (rd_idx_i == c_cyc_idx) begin
            w_rd_sel = w_cyc_cnt;
        end
    end

    // Samples the pre-update counter values, so a simultaneous increment
    // is only visible on the following read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_sel;
        end
    end

    assign rd_data_o = r_rd_data;
    assign cycle_o   = w_cyc_cnt;
    assign running_o = r_state[0];
    assign done_o    = r_state[1];
    assign ovf_o     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipe_event_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_event_counter
// Description : Self-checking bench: a 32-bit/limit-30 instance and a
//               4-bit/unlimited instance driven by shared directed stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_event_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        clear;
    logic [3:0]  ev;
    logic [2:0]  idx;
    logic        chk_en = 1'b0;

    logic [31:0] a_rd, a_cyc;
    logic        a_run, a_done;
    logic [3:0]  a_ovf;
    logic [3:0]  b_rd, b_cyc;
    logic        b_run, b_done;
    logic [3:0]  b_ovf;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_event_counter #(.NUM_EVT(4), .CNT_W(32), .CYC_LIMIT(30)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
        .event_i(ev), .rd_idx_i(idx), .rd_data_o(a_rd), .cycle_o(a_cyc),
        .running_o(a_run), .done_o(a_done), .ovf_o(a_ovf)
    );

    pipe_event_counter #(.NUM_EVT(4), .CNT_W(4), .CYC_LIMIT(0)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
        .event_i(ev), .rd_idx_i(idx), .rd_data_o(b_rd), .cycle_o(b_cyc),
        .running_o(b_run), .done_o(b_done), .ovf_o(b_ovf)
    );

    // Reference model: index 0 = instance a, index 1 = instance b.
    // Mode 0 = idle, 1 = running, 2 = window closed.
    longint     m_cyc [2];
    longint     m_evt [2][4];
    logic [3:0] m_ovf [2];
    int         m_mode[2];
    longint     m_rd  [2];
    longint     c_max [2] = '{64'd4294967295, 64'd15};
    longint     c_lim [2] = '{64'd30, 64'd0};

    function automatic longint sel(int m);
        if (idx < 3'd4) return m_evt[m][idx];
        if (idx == 3'd4) return m_cyc[m];
        return 0;
    endfunction

    function automatic longint cyc_after(int m);
        return (m_cyc[m] >= c_max[m]) ? c_max[m] : m_cyc[m] + 1;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                m_cyc[m]  <= 0;
                m_ovf[m]  <= '0;
                m_mode[m] <= 0;
                m_rd[m]   <= 0;
                for (int k = 0; k < 4; k++) m_evt[m][k] <= 0;
            end else begin
                m_rd[m] <= sel(m);
                if (clear) begin
                    m_cyc[m]  <= 0;
                    m_ovf[m]  <= '0;
                    m_mode[m] <= 0;
                    for (int k = 0; k < 4; k++) m_evt[m][k] <= 0;
                end else if (start && m_mode[m] != 2) begin
                    m_cyc[m]  <= cyc_after(m);
                    m_mode[m] <= (c_lim[m] != 0 && cyc_after(m) == c_lim[m]) ? 2 : 1;
                    for (int k = 0; k < 4; k++) begin
                        if (ev[k]) begin
                            if (m_evt[m][k] >= c_max[m]) m_ovf[m][k] <= 1'b1;
                            else m_evt[m][k] <= m_evt[m][k] + 1;
                        end
                    end
                end else if (m_mode[m] == 1) begin
                    m_mode[m] <= 0;
                end
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("a.rd_data", a_rd, m_rd[0]);
            check("a.cycle",   a_cyc, m_cyc[0]);
            check("a.running", a_run, m_mode[0] == 1);
            check("a.done",    a_done, m_mode[0] == 2);
            check("a.ovf",     a_ovf, m_ovf[0]);
            check("b.rd_data", b_rd, m_rd[1]);
            check("b.cycle",   b_cyc, m_cyc[1]);
            check("b.running", b_run, m_mode[1] == 1);
            check("b.done",    b_done, m_mode[1] == 2);
            check("b.ovf",     b_ovf, m_ovf[1]);
        end
    end

    task automatic edges(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        start = 1'b0;
        edges(1);
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; clear = 1'b0; ev = '0; idx = '0;
        #1 rst = 1'b1;
        chk_en = 1'b1;
        edges(2);
        check("reset a.cycle", a_cyc, 0);
        check("reset a.rd", a_rd, 0);
        check("reset a.running", a_run, 0);
        check("reset a.done", a_done, 0);
        rst = 1'b0;

        // Full window with no events
        start = 1'b1;
        edges(30);
        check("win a.done", a_done, 1);
        check("win a.cycle", a_cyc, 30);
        check("win a.running", a_run, 0);
        check("sat b.cycle", b_cyc, 15);
        check("sat b.running", b_run, 1);
        edges(3);
        check("frozen a.cycle", a_cyc, 30);
        check("frozen a.done", a_done, 1);

        // Event counts and read port
        do_clear();
        check("clr a.cycle", a_cyc, 0);
        check("clr a.done", a_done, 0);
        start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            ev = {2'b00, (i >= 10 && i < 13), (i < 7)};
            edges(1);
        end
        ev = '0;
        idx = 3'd0; edges(1); check("rd idx0", a_rd, 7);
        idx = 3'd1; edges(1); check("rd idx1", a_rd, 3);
        idx = 3'd4; edges(1); check("rd idx4", a_rd, 30);
        idx = 3'd5; edges(1); check("rd idx5", a_rd, 0);
        idx = 3'd7; edges(1); check("rd idx7", a_rd, 0);

        // Pause and resume
        do_clear();
        start = 1'b1;
        edges(10);
        check("pre-pause a.cycle", a_cyc, 10);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            edges(1);
            check("pause a.cycle", a_cyc, 10);
            check("pause a.running", a_run, 0);
        end
        start = 1'b1;
        edges(19);
        check("resume a.done early", a_done, 0);
        check("resume a.cycle", a_cyc, 29);
        edges(1);
        check("resume a.done", a_done, 1);
        check("resume a.cycle end", a_cyc, 30);

        // Saturation on the 4-bit instance
        do_clear();
        start = 1'b1;
        ev = 4'b0100;
        edges(20);
        ev = '0;
        start = 1'b0;
        idx = 3'd2;
        edges(1);
        check("b.rd idx2 sat", b_rd, 15);
        check("b.ovf sat", b_ovf, 4'b0100);
        do_clear();
        check("b.cycle cleared", b_cyc, 0);
        check("b.ovf cleared", b_ovf, 0);
        check("b.running cleared", b_run, 0);

        // Clear from DONE while start held
        start = 1'b1;
        edges(30);
        check("pre-clear a.done", a_done, 1);
        clear = 1'b1;
        edges(1);
        check("clr-done a.done", a_done, 0);
        check("clr-done a.running", a_run, 0);
        check("clr-done a.cycle", a_cyc, 0);
        clear = 1'b0;
        edges(1);
        check("post-clr a.running", a_run, 1);
        check("post-clr a.cycle", a_cyc, 1);

        // Asynchronous reset between edges
        edges(3);
        #2 rst = 1'b1;
        #1;
        check("async a.cycle", a_cyc, 0);
        check("async a.running", a_run, 0);
        check("async a.rd", a_rd, 0);
        check("async b.cycle", b_cyc, 0);
        edges(1);
        rst = 1'b0;
        edges(1);
        check("restart a.cycle", a_cyc, 1);
        check("restart a.running", a_run, 1);

        edges(2);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_event_counter.md
Name: pipe_event_counter

Overview:
- Synthesizable, parametrised performance monitor for the pipelined CPU. Counts cycles and up to NUM_EVT per-cycle event strobes, such as stall and flush.
- Counting runs inside a bounded window: it starts on start_i and stops automatically after CYC_LIMIT cycles.
- Sits beside the CPU top level. Its strobes come from hazard detection (stall) and the branch/jump flush OR (flush).
- Results are read back through a registered indexed read port.

Parameters:
- NUM_EVT, 4, number of event channels (bit 0 = stall, bit 1 = flush; others free).
- CNT_W, 32, width of every counter, including the cycle counter.
- CYC_LIMIT, 30, cycle count at which the window closes; 0 = unlimited.
- IDX_W, $clog2(NUM_EVT+1), read index width (derived; do not override).

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  level enable; high = CPU running, count.
- clear_i  in  1  synchronous clear of all counters and flags; FSM returns to IDLE.
- event_i  in  NUM_EVT  per-cycle event strobes, sampled on clk_i rising edge.
- rd_idx_i  in  IDX_W  counter select: 0..NUM_EVT-1 = event counters; NUM_EVT = cycle counter.
- rd_data_o  out  CNT_W  registered read data.
- cycle_o  out  CNT_W  live cycle counter.
- running_o  out  1  high while in RUN.
- done_o  out  1  high while in DONE (window closed).
- ovf_o  out  NUM_EVT  sticky per-channel saturation flags.

Behaviour:
- Reset (async, rst_i=1): FSM=IDLE. All counters, rd_data_o, cycle_o, ovf_o = 0; running_o=0; done_o=0. Reset mid-window discards all counts immediately.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN: on an edge with start_i=1. Counting begins in that same edge; cycle becomes 1.
  - RUN -> IDLE: start_i=0 at an edge. Nothing is counted on that edge; counters hold. Re-asserting start_i resumes from the held values.
  - RUN -> DONE: the edge at which the cycle counter becomes CYC_LIMIT (CYC_LIMIT != 0). Events on that edge are still counted.
  - DONE: all counters frozen; start_i and event_i ignored; stays until clear_i or rst_i.
- Per counted edge: cycle += 1; evt[k] += event_i[k] for each k.
- Saturation:
  - All counters saturate at 2^CNT_W-1 and never wrap.
  - ovf_o[k] sets on the edge where evt[k] is saturated and event_i[k]=1, and stays set until clear_i or reset.
  - When cycle saturates with CYC_LIMIT=0, the FSM stays in RUN and cycle holds.
- clear_i: priority over all FSM transitions. On that edge, counters and ovf_o go to 0 and the FSM goes to IDLE, even if start_i=1. Counting resumes on the next edge.
- Read port:
  - rd_data_o <= selected counter value on each edge, so data is valid one cycle after rd_idx_i.
  - Index > NUM_EVT returns 0.
  - The value read is the pre-update count; on a simultaneous update, the old value is returned.
- running_o and done_o are decoded from FSM registers (glitch-free) and are never both high.

Decomposition:
- Shared package pipe_perf_pkg:
  - FSM state enum (IDLE/RUN/DONE).
  - Event index constants EVT_STALL=0, EVT_FLUSH=1.
- One sub-module, sat_counter (width CNT_W; inputs en, inc, clr; outputs count, sat). Instantiated NUM_EVT times via generate, plus once for the cycle counter.
- FSM and read mux live in the top level.

Test Plan:
- Reset then start_i=1, event_i=4'b0000, default params -> after 30 edges: done_o=1, cycle_o=30, running_o=0. Further edges leave cycle_o=30.
- start_i=1; bit0 high on 7 edges, bit1 high on 3 edges within the window -> read idx 0 = 7, idx 1 = 3, idx 4 = 30, idx 5 = 0, each one cycle after the index is applied.
- Pause: start_i high for 10 edges, low for 5, high again -> cycle_o=10 during the pause; DONE reached 20 edges after resume.
- CNT_W=4, CYC_LIMIT=0, bit2 held high for 20 edges -> idx 2 reads 15, ovf_o[2]=1, other ovf bits 0; clear_i -> all zero, FSM in IDLE.
- clear_i asserted in DONE with start_i=1 -> next edge IDLE with counters 0; following edge RUN with cycle_o=1.
- rst_i pulsed asynchronously mid-RUN (between edges) -> outputs 0 immediately. With start_i still high, counting restarts from 1 on the first edge after release.
